// File: rtl/adc_max10_responder_if.sv
// Command/response bundle between an ADC sequencer core (master) and the
// modular-ADC side (slave), including PLL lock and the framing-error flag.
interface adc_max10_responder_if;
    logic        ADC_PLL_Locked;
    logic        ADC_C_Valid;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_C_SOP;
    logic        ADC_C_EOP;
    logic        ADC_C_Ready;
    logic        ADC_R_Valid;
    logic [4:0]  ADC_R_Channel;
    logic [11:0] ADC_R_Data;
    logic        ADC_R_SOP;
    logic        ADC_R_EOP;
    logic        PROTO_ERR;

    modport master (
        output ADC_PLL_Locked, ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
        input  ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data,
               ADC_R_SOP, ADC_R_EOP, PROTO_ERR
    );

    modport slave (
        input  ADC_PLL_Locked, ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
        output ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data,
               ADC_R_SOP, ADC_R_EOP, PROTO_ERR
    );
endinterface

// File: rtl/adc_max10_responder.sv
// Deterministic stand-in for the MAX10 modular ADC: one 12-bit response per
// accepted command after a fixed conversion time, with packet-framing checks.
module adc_max10_responder #(
    parameter int unsigned CONV_CYCLES = 20,
    parameter logic [11:0] TEMP_CODE   = 12'h8A0
) (
    input  logic                        CLK,
    input  logic                        RESETn,
    adc_max10_responder_if.slave        adc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 32'd1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  ch_q, ch_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [6:0]  sample_q, sample_d;
    logic        pkt_open_q, pkt_open_d;
    logic        err_q, err_d;
    logic        run_q;
    logic        r_valid_q, r_valid_d;
    logic [4:0]  r_ch_q, r_ch_d;
    logic [11:0] r_data_q, r_data_d;
    logic        r_sop_q, r_sop_d;
    logic        r_eop_q, r_eop_d;

    logic        ready_s;
    logic        accept_s;
    logic        frame_bad_s;

    // Channel-to-data mapping: ADC pins carry a traceable channel/sample tag.
    function automatic logic [11:0] resp_data(input logic [4:0] ch, input logic [6:0] cnt);
        logic [11:0] d;
        if (ch <= 5'd16) begin
            d = {ch, cnt};
        end else if (ch == 5'd17) begin
            d = TEMP_CODE;
        end else begin
            d = 12'h000;
        end
        return d;
    endfunction

    // run_q keeps Ready low until the first edge after reset release
    assign ready_s     = run_q & (state_q == ST_IDLE) & adc.ADC_PLL_Locked;
    assign accept_s    = ready_s & adc.ADC_C_Valid;
    assign frame_bad_s = (adc.ADC_C_SOP == pkt_open_q);

    // Next-state: command acceptance, conversion countdown, response, abort
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        sample_d   = sample_q;
        pkt_open_d = pkt_open_q;
        err_d      = err_q;
        r_valid_d  = 1'b0;
        r_ch_d     = r_ch_q;
        r_data_d   = r_data_q;
        r_sop_d    = r_sop_q;
        r_eop_d    = r_eop_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    ch_d    = adc.ADC_C_Channel;
                    sop_d   = adc.ADC_C_SOP;
                    eop_d   = adc.ADC_C_EOP;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_CONV;
                    err_d   = err_q | frame_bad_s;
                    if (adc.ADC_C_EOP) begin
                        pkt_open_d = 1'b0;
                    end else if (adc.ADC_C_SOP) begin
                        pkt_open_d = 1'b1;
                    end else begin
                        pkt_open_d = pkt_open_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (!adc.ADC_PLL_Locked) begin
                    state_d    = ST_IDLE;
                    pkt_open_d = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    state_d   = ST_RESP;
                    r_valid_d = 1'b1;
                    r_ch_d    = ch_q;
                    r_data_d  = resp_data(ch_q, sample_q);
                    r_sop_d   = sop_q;
                    r_eop_d   = eop_q;
                    sample_d  = sample_q + 7'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!adc.ADC_PLL_Locked) begin
                    pkt_open_d = 1'b0;
                end else begin
                    pkt_open_d = pkt_open_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            ch_q       <= 5'd0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            sample_q   <= 7'd0;
            pkt_open_q <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
            r_valid_q  <= 1'b0;
            r_ch_q     <= 5'd0;
            r_data_q   <= 12'h000;
            r_sop_q    <= 1'b0;
            r_eop_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            sample_q   <= sample_d;
            pkt_open_q <= pkt_open_d;
            err_q      <= err_d;
            run_q      <= 1'b1;
            r_valid_q  <= r_valid_d;
            r_ch_q     <= r_ch_d;
            r_data_q   <= r_data_d;
            r_sop_q    <= r_sop_d;
            r_eop_q    <= r_eop_d;
        end
    end

    assign adc.ADC_C_Ready   = ready_s;
    assign adc.ADC_R_Valid   = r_valid_q;
    assign adc.ADC_R_Channel = r_ch_q;
    assign adc.ADC_R_Data    = r_data_q;
    assign adc.ADC_R_SOP     = r_sop_q;
    assign adc.ADC_R_EOP     = r_eop_q;
    assign adc.PROTO_ERR     = err_q;

endmodule

// File: tb/tb_adc_max10_responder.sv
// Self-checking bench for adc_max10_responder: scenario tasks compared against
// a behavioural model of sample counting, packet framing and channel data.
module tb_adc_max10_responder;

    localparam int CONV = 20;

    logic CLK = 1'b0;
    logic RESETn;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_resp = 0;

    // behavioural model state
    int   m_cnt = 0;
    bit   m_pkt = 1'b0;
    bit   m_err = 1'b0;

    adc_max10_responder_if adc_if();

    adc_max10_responder #(.CONV_CYCLES(CONV), .TEMP_CODE(12'h8A0)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .adc    (adc_if)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    initial begin
        #900000;
        $display("FAIL watchdog time=%0t expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] exp_data(int ch, int cnt);
        if (ch < 17) return 12'(ch * 128 + cnt);
        else if (ch == 17) return 12'h8A0;
        else return 12'h000;
    endfunction

    task automatic apply_reset();
        @(negedge CLK);
        RESETn = 1'b0;
        adc_if.ADC_C_Valid = 1'b0;
        adc_if.ADC_PLL_Locked = 1'b1;
        repeat (2) @(negedge CLK);
        m_cnt = 0; m_pkt = 1'b0; m_err = 1'b0;
        RESETn = 1'b1;
        @(negedge CLK);
    endtask

    // Send one command and check its whole lifetime; called at a negedge.
    task automatic do_cmd(input int ch, input bit sop, input bit eop);
        int t;
        logic [11:0] ed;
        adc_if.ADC_C_Valid   = 1'b1;
        adc_if.ADC_C_Channel = 5'(ch);
        adc_if.ADC_C_SOP     = sop;
        adc_if.ADC_C_EOP     = eop;
        t = 0;
        while (adc_if.ADC_C_Ready !== 1'b1 && t < 64) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (adc_if.ADC_C_Ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout ch=%0d ready=%b expected 1", ch, adc_if.ADC_C_Ready);
            adc_if.ADC_C_Valid = 1'b0;
            return;
        end
        if (sop == m_pkt) m_err = 1'b1;
        if (eop) m_pkt = 1'b0;
        else if (sop) m_pkt = 1'b1;
        ed = exp_data(ch, m_cnt);
        @(negedge CLK);
        adc_if.ADC_C_Valid = 1'b0;
        for (int j = 0; j <= CONV; j++) begin
            if (j > 0) @(negedge CLK);
            checks++;
            if (adc_if.ADC_R_Valid !== 1'(j == CONV)) begin
                errors++;
                $display("FAIL r_valid_timing ch=%0d cyc_after_accept=%0d got=%b expected=%b",
                         ch, j, adc_if.ADC_R_Valid, (j == CONV));
            end
            checks++;
            if (adc_if.ADC_C_Ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_busy ch=%0d cyc_after_accept=%0d got=%b expected 0",
                         ch, j, adc_if.ADC_C_Ready);
            end
            if (j == 0) begin
                checks++;
                if (adc_if.PROTO_ERR !== m_err) begin
                    errors++;
                    $display("FAIL proto_err ch=%0d got=%b expected=%b", ch, adc_if.PROTO_ERR, m_err);
                end
            end
        end
        last_resp = cyc;
        checks++;
        if (adc_if.ADC_R_Channel !== 5'(ch) || adc_if.ADC_R_Data !== ed ||
            adc_if.ADC_R_SOP !== sop || adc_if.ADC_R_EOP !== eop) begin
            errors++;
            $display("FAIL resp_fields got ch=%0d data=%h sop=%b eop=%b expected ch=%0d data=%h sop=%b eop=%b",
                     adc_if.ADC_R_Channel, adc_if.ADC_R_Data, adc_if.ADC_R_SOP, adc_if.ADC_R_EOP,
                     ch, ed, sop, eop);
        end
        m_cnt = (m_cnt + 1) % 128;
        @(negedge CLK);
        checks++;
        if (adc_if.ADC_R_Valid !== 1'b0 || adc_if.ADC_C_Ready !== 1'b1 || adc_if.ADC_R_Data !== ed) begin
            errors++;
            $display("FAIL after_resp got valid=%b ready=%b data=%h expected valid=0 ready=1 data=%h",
                     adc_if.ADC_R_Valid, adc_if.ADC_C_Ready, adc_if.ADC_R_Data, ed);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (adc_if.ADC_C_Ready !== 1'b0 || adc_if.ADC_R_Valid !== 1'b0 || adc_if.ADC_R_Channel !== 5'd0 ||
            adc_if.ADC_R_Data !== 12'h000 || adc_if.ADC_R_SOP !== 1'b0 || adc_if.ADC_R_EOP !== 1'b0 ||
            adc_if.PROTO_ERR !== 1'b0) begin
            errors++;
            $display("FAIL %s got rdy=%b val=%b ch=%0d data=%h sop=%b eop=%b err=%b expected all 0",
                     name, adc_if.ADC_C_Ready, adc_if.ADC_R_Valid, adc_if.ADC_R_Channel,
                     adc_if.ADC_R_Data, adc_if.ADC_R_SOP, adc_if.ADC_R_EOP, adc_if.PROTO_ERR);
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        adc_if.ADC_PLL_Locked = 1'b1;
        adc_if.ADC_C_Valid = 1'b0;
        adc_if.ADC_C_Channel = 5'd0;
        adc_if.ADC_C_SOP = 1'b0;
        adc_if.ADC_C_EOP = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset_values");
        RESETn = 1'b1;
        #1;
        check_all_zero("ready_before_first_edge");
        @(negedge CLK);
        checks++;
        if (adc_if.ADC_C_Ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got=%b expected 1", adc_if.ADC_C_Ready);
        end
    endtask

    task automatic test_single();
        apply_reset();
        do_cmd(1, 1'b1, 1'b1);
        checks++;
        if (adc_if.ADC_R_Data !== 12'h080) begin
            errors++;
            $display("FAIL single_data got=%h expected 080", adc_if.ADC_R_Data);
        end
    endtask

    task automatic test_back_to_back();
        int r1, r2;
        apply_reset();
        do_cmd(4, 1'b1, 1'b0); r1 = last_resp;
        do_cmd(5, 1'b0, 1'b0); r2 = last_resp;
        checks++;
        if (r2 - r1 !== CONV + 2) begin
            errors++;
            $display("FAIL throughput got=%0d expected=%0d", r2 - r1, CONV + 2);
        end
        do_cmd(6, 1'b0, 1'b1);
        checks++;
        if (last_resp - r2 !== CONV + 2 || adc_if.ADC_R_Data !== 12'h302) begin
            errors++;
            $display("FAIL seq_last got gap=%0d data=%h expected gap=%0d data=302",
                     last_resp - r2, adc_if.ADC_R_Data, CONV + 2);
        end
    endtask

    task automatic test_temp_unmapped();
        apply_reset();
        do_cmd(17, 1'b1, 1'b1);
        do_cmd(25, 1'b1, 1'b1);
        do_cmd(0, 1'b1, 1'b1);
        checks++;
        if (adc_if.ADC_R_Data !== 12'h002) begin
            errors++;
            $display("FAIL sample_advance got=%h expected 002", adc_if.ADC_R_Data);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 1; i <= 130; i++) begin
            do_cmd(0, 1'b1, 1'b1);
            if (i == 128 || i == 129) begin
                checks++;
                if (adc_if.ADC_R_Data !== ((i == 128) ? 12'h07F : 12'h000)) begin
                    errors++;
                    $display("FAIL wrap resp=%0d got=%h", i, adc_if.ADC_R_Data);
                end
            end
        end
    endtask

    task automatic test_proto_err();
        apply_reset();
        do_cmd(2, 1'b0, 1'b0);
        apply_reset();
        do_cmd(3, 1'b1, 1'b0);
        do_cmd(3, 1'b1, 1'b0);
        do_cmd(3, 1'b0, 1'b1);
        checks++;
        if (adc_if.PROTO_ERR !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky got=%b expected 1", adc_if.PROTO_ERR);
        end
    endtask

    task automatic test_lock_loss();
        int t;
        apply_reset();
        do_cmd(2, 1'b1, 1'b0);
        adc_if.ADC_C_Valid = 1'b1;
        adc_if.ADC_C_Channel = 5'd7;
        adc_if.ADC_C_SOP = 1'b0;
        adc_if.ADC_C_EOP = 1'b0;
        t = 0;
        while (adc_if.ADC_C_Ready !== 1'b1 && t < 64) begin @(negedge CLK); t++; end
        @(negedge CLK);
        adc_if.ADC_C_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        adc_if.ADC_PLL_Locked = 1'b0;
        adc_if.ADC_C_Valid = 1'b1;
        m_pkt = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge CLK);
            checks++;
            if (adc_if.ADC_R_Valid !== 1'b0 || adc_if.ADC_C_Ready !== 1'b0) begin
                errors++;
                $display("FAIL lock_abort cyc=%0d got valid=%b ready=%b expected 0 0",
                         j, adc_if.ADC_R_Valid, adc_if.ADC_C_Ready);
            end
        end
        adc_if.ADC_C_Valid = 1'b0;
        adc_if.ADC_PLL_Locked = 1'b1;
        @(negedge CLK);
        checks++;
        if (adc_if.ADC_C_Ready !== 1'b1) begin
            errors++;
            $display("FAIL relock_ready got=%b expected 1", adc_if.ADC_C_Ready);
        end
        do_cmd(3, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_cmd(10, 1'b0, 1'b0);
        adc_if.ADC_C_Valid = 1'b1;
        adc_if.ADC_C_Channel = 5'd9;
        adc_if.ADC_C_SOP = 1'b1;
        adc_if.ADC_C_EOP = 1'b1;
        @(negedge CLK);
        adc_if.ADC_C_Valid = 1'b0;
        repeat (6) @(negedge CLK);
        #2;
        RESETn = 1'b0;
        #1;
        check_all_zero("reset_mid_conv");
        m_cnt = 0; m_pkt = 1'b0; m_err = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge CLK);
            checks++;
            if (adc_if.ADC_R_Valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_resp cyc=%0d got=%b expected 0", j, adc_if.ADC_R_Valid);
            end
        end
        do_cmd(1, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 25; i++) begin
            do_cmd(int'($urandom_range(31)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_temp_unmapped();
        test_wrap();
        test_proto_err();
        test_lock_loss();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
